hilo_unit: RTL
==============

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock, first port); rst input 1 (synchronous active-high reset, second port).
REQ-002 op_valid input 1: instruction request present this cycle.
REQ-003 op_code input 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved.
REQ-004 rs_val, rt_val input 32: operands, rs = dividend/multiplicand, rt = divisor/multiplier, rs = MTHI/MTLO source.
REQ-005 mf_req input 1: MFHI/MFLO read pending this cycle.
REQ-006 hi, lo output 32: architectural HI/LO registers, driven directly from flops.
REQ-007 busy output 1: high while state is not IDLE.
REQ-008 stall output 1: combinational; = busy & (op_valid | mf_req).
REQ-009 div_start output 1, div_a/div_b output 32, div_signed output 1: launch port to the external iterative divider.
REQ-010 div_q, div_r input 32, div_done input 1: divider result port; div_done is a one-cycle pulse.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV_START, DIV_WAIT, encoded in hilo_pkg.
REQ-012 SHALL accept an op only when state = IDLE and op_valid = 1; ops presented while busy SHALL NOT be accepted, and upstream holds them under stall.
REQ-013 Accepted MULT/MULTU SHALL register rs_val, rt_val and a signed flag, then go IDLE->MUL; in MUL, HI:LO SHALL load the full 64-bit product (signed for MULT, unsigned for MULTU), then go MUL->IDLE. HI/LO are updated at edge N+1 after acceptance at edge N.
REQ-014 Accepted DIV/DIVU with rt_val != 0 SHALL register operands, then go IDLE->DIV_START; in DIV_START, div_start = 1 for exactly one cycle, with div_a/div_b/div_signed held from the registers; then go to DIV_WAIT.
REQ-015 In DIV_WAIT, on div_done = 1: LO <= div_q, HI <= div_r, state -> IDLE; there is no timeout.
REQ-016 DIV/DIVU with rt_val = 0 SHALL leave HI/LO unchanged, remain in IDLE, and never assert div_start.
REQ-017 MTHI/MTLO accepted in IDLE SHALL write rs_val into HI/LO at the same edge, with no busy cycle.
REQ-018 Op codes NONE and 7 SHALL be ignored.
REQ-019 div_a, div_b and div_signed SHALL be stable from DIV_START until div_done.
REQ-020 div_done outside DIV_WAIT SHALL be ignored.
REQ-021 mf_req in IDLE SHALL not stall; hi/lo reflect all completed ops, and back-to-back MTHI then MFHI reads the new value on the next cycle.

Reset
REQ-022 rst SHALL force state IDLE, hi = 0, lo = 0, div_start = 0, and clear operand registers, at the next rising edge, taking priority over every other event, including mid-MUL and mid-DIV_WAIT.
REQ-023 After reset, busy and stall SHALL be 0.
REQ-024 The divider SHALL share rst, so there is no stale div_done after reset.

Structure
REQ-025 hilo_pkg SHALL hold the op_code enum, the FSM state enum and the 32-bit word width constant.
REQ-026 One sub-module, hilo_mult, SHALL perform the combinational 32x32->64 signed/unsigned multiply; the divider stays external.

Verification
REQ-027 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-029 DIV rs=-7, rt=2, with model divider returning q=0xFFFFFFFD, r=0xFFFFFFFF after 33 cycles -> single div_start pulse; div_signed=1; stall for op_valid/mf_req during the wait; LO=-3, HI=-1 after div_done.
REQ-030 DIVU rs=100, rt=0 -> no div_start, busy stays 0, HI/LO unchanged.
REQ-031 MTHI 0x12345678 then MFHI the next cycle -> hi=0x12345678, stall=0; an MTLO issued during DIV_WAIT is stalled and applied only after completion.
REQ-032 rst asserted mid-DIV_WAIT -> next edge: state IDLE, hi=lo=0, busy=0; a later div_done pulse is ignored.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO unit.
// Op codes, FSM states and the datapath word width.
package hilo_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MUL       = 2'd1,
    S_DIV_START = 2'd2,
    S_DIV_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_mult.sv
// Combinational 32x32->64 multiplier.
// One sign-extension bit covers both signed and unsigned forms.
module hilo_mult
  import hilo_pkg::*;
(
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              signed_i,
  output logic [2*XLEN-1:0] prod_o
);

  logic signed [XLEN:0]     a_x;
  logic signed [XLEN:0]     b_x;
  logic signed [2*XLEN+1:0] p_x;

  assign a_x    = {signed_i & a_i[XLEN-1], a_i};
  assign b_x    = {signed_i & b_i[XLEN-1], b_i};
  assign p_x    = a_x * b_x;
  assign prod_o = p_x[2*XLEN-1:0];

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: multiply, divider launch/collect, MTHI/MTLO.
// The iterative divider is external and shares rst.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mf_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            div_start,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_signed,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  input  logic            div_done
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sgn_q, sgn_d;

  op_e             op;
  logic            accept;
  logic            is_mul, is_div;
  logic            is_mthi, is_mtlo;
  logic [2*XLEN-1:0] prod;

  assign op      = op_e'(op_code);
  assign accept  = (state_q == S_IDLE) & op_valid;
  assign is_mul  = accept & ((op == OP_MULT) | (op == OP_MULTU));
  // Divide by zero is dropped here; the divider never sees it.
  assign is_div  = accept & ((op == OP_DIV) | (op == OP_DIVU))
                 & (rt_val != '0);
  assign is_mthi = accept & (op == OP_MTHI);
  assign is_mtlo = accept & (op == OP_MTLO);

  hilo_mult u_mult (
    .a_i      (a_q),
    .b_i      (b_q),
    .signed_i (sgn_q),
    .prod_o   (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_mul:  state_d = S_MUL;
          is_div:  state_d = S_DIV_START;
          default: state_d = S_IDLE;
        endcase
      end
      S_MUL:       state_d = S_IDLE;
      S_DIV_START: state_d = S_DIV_WAIT;
      S_DIV_WAIT:  if (div_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sgn_d = sgn_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (is_mul | is_div) begin
      a_d   = rs_val;
      b_d   = rt_val;
      sgn_d = (op == OP_MULT) | (op == OP_DIV);
    end
    if (is_mthi) hi_d = rs_val;
    if (is_mtlo) lo_d = rs_val;
    if (state_q == S_MUL) begin
      hi_d = prod[2*XLEN-1:XLEN];
      lo_d = prod[XLEN-1:0];
    end
    if ((state_q == S_DIV_WAIT) & div_done) begin
      hi_d = div_r;
      lo_d = div_q;
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    stall      = busy & (op_valid | mf_req);
    div_start  = (state_q == S_DIV_START);
    div_a      = a_q;
    div_b      = b_q;
    div_signed = sgn_q;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
